// File: rtl/clock_div_pkg.sv
// Shared types and helpers for the multi-channel clock divider.
package clock_div_pkg;

  localparam int DIV_MIN = 2;

  typedef enum logic [1:0] {CH_IDLE, CH_RUN, CH_STOP} ch_state_e;

  // Divisors below DIV_MIN cannot produce a square wave, so they are promoted.
  function automatic logic [31:0] clamp_div(input logic [31:0] d);
    return (d < 32'(DIV_MIN)) ? 32'(DIV_MIN) : d;
  endfunction

endpackage

// File: rtl/clock_div_ch.sv
// One divider channel: period counter, deferred divisor update and registered clock/tick outputs.
module clock_div_ch
  import clock_div_pkg::*;
#(
  parameter int               CNT_W       = 16,
  parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(100)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  output logic             div_clk,
  output logic             tick,
  output logic             busy,
  output logic             pend
);

  ch_state_e        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] div_reg, div_next;
  logic [CNT_W-1:0] pval_reg, pval_next;
  logic             pend_reg, pend_next;
  logic             clk_reg, tick_reg;
  logic             wrap;
  logic             run_next;
  logic [CNT_W:0]   hi_next;

  assign wrap = (cnt_reg == div_reg - CNT_W'(1));

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    div_next   = div_reg;
    pval_next  = pval_reg;
    pend_next  = pend_reg;
    if (state_reg == CH_IDLE) begin
      if (wr) div_next = wr_div;
      if (en) begin
        state_next = CH_RUN;
        cnt_next   = '0;
      end
    end else if (sync || wrap) begin
      // Period boundary: a same-cycle write beats an older pending value.
      cnt_next   = '0;
      pend_next  = 1'b0;
      state_next = en ? CH_RUN : CH_IDLE;
      if (wr)            div_next = wr_div;
      else if (pend_reg) div_next = pval_reg;
    end else begin
      cnt_next   = cnt_reg + CNT_W'(1);
      state_next = en ? CH_RUN : CH_STOP;
      if (wr) begin
        pval_next = wr_div;
        pend_next = 1'b1;
      end
    end
  end

  assign run_next = (state_next != CH_IDLE);
  assign hi_next  = ({1'b0, div_next} + 1'b1) >> 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= CH_IDLE;
      cnt_reg   <= '0;
      div_reg   <= DEFAULT_DIV;
      pval_reg  <= '0;
      pend_reg  <= 1'b0;
      clk_reg   <= 1'b0;
      tick_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      div_reg   <= div_next;
      pval_reg  <= pval_next;
      pend_reg  <= pend_next;
      clk_reg   <= run_next && ({1'b0, cnt_next} < hi_next);
      tick_reg  <= run_next && (cnt_next == '0);
    end
  end

  assign div_clk = clk_reg;
  assign tick    = tick_reg;
  assign busy    = (state_reg != CH_IDLE);
  assign pend    = pend_reg;

endmodule

// File: rtl/clock_div_multi.sv
// Multi-channel programmable clock/tick generator: write decode and sync fan-out around per-channel dividers.
module clock_div_multi
  import clock_div_pkg::*;
#(
  parameter real CLOCK_SYS = 100e6,
  parameter real CLOCK_OUT = 1e6,
  parameter int  NUM_CH    = 4,
  parameter int  CNT_W     = 16,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NUM_CH-1:0] en_i,
  input  logic              sync_i,
  input  logic              wr_en_i,
  input  logic [CH_W-1:0]   wr_ch_i,
  input  logic [CNT_W-1:0]  wr_div_i,
  output logic [NUM_CH-1:0] clk_o,
  output logic [NUM_CH-1:0] tick_o,
  output logic [NUM_CH-1:0] busy_o,
  output logic [NUM_CH-1:0] pend_o
);

  localparam int               DIV_RAW     = int'(CLOCK_SYS / CLOCK_OUT);
  localparam logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(clamp_div(32'(DIV_RAW)));

  logic [CNT_W-1:0] wr_div_c;

  assign wr_div_c = CNT_W'(clamp_div(32'(wr_div_i)));

  // Channel numbers beyond NUM_CH match no instance, so such writes fall away.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic wr_hit;
    assign wr_hit = wr_en_i && (wr_ch_i == CH_W'(gi));

    clock_div_ch #(
      .CNT_W      (CNT_W),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_ch (
      .clk    (clk_i),
      .rst_n  (rst_ni),
      .en     (en_i[gi]),
      .sync   (sync_i),
      .wr     (wr_hit),
      .wr_div (wr_div_c),
      .div_clk(clk_o[gi]),
      .tick   (tick_o[gi]),
      .busy   (busy_o[gi]),
      .pend   (pend_o[gi])
    );
  end

endmodule
